// File: rtl/mem_responder.sv
// mem_responder: serializes line/word cache requests into one-word-per-cycle
// accesses on a single-port SRAM with fixed read latency.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef CACHE_BITS
`define CACHE_BITS 2
`endif
`ifndef CACHE_SIZE
`define CACHE_SIZE (1 << `CACHE_BITS)
`endif

module mem_responder #(
    parameter int ADDR_SIZE  = `ADDR_SIZE,
    parameter int CACHE_BITS = `CACHE_BITS,
    parameter int CACHE_SIZE = `CACHE_SIZE,
    parameter int RD_LAT     = 1
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       mem_w_line,
    input  logic                       mem_r_line,
    input  logic                       mem_w_one,
    input  logic                       mem_r_one,
    input  logic [ADDR_SIZE-1:0]       mem_addr,
    input  logic [CACHE_SIZE-1:0][31:0] line_store,
    output logic [CACHE_SIZE-1:0][31:0] line_read,
    output logic                       mem_ready,
    output logic                       mem_done,
    output logic                       proto_err,
    output logic [ADDR_SIZE-1:0]       sram_addr,
    output logic                       sram_we,
    output logic                       sram_re,
    output logic [31:0]                sram_wdata,
    input  logic [31:0]                sram_rdata
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, READ_WAIT, DONE, RELEASE} state_t;

    state_t                         state_q;
    logic [3:0]                     sel_q;
    logic [CACHE_BITS-1:0]          last_q, cnt_q, rcnt_q;
    logic [CACHE_SIZE-1:0][31:0]    wbuf_q, rbuf_q;
    logic [RD_LAT-1:0]              pipe_q;
    logic [ADDR_SIZE-1:0]           sram_addr_q;
    logic [31:0]                    sram_wdata_q;
    logic                           sram_we_q, sram_re_q, mem_done_q, mem_ready_q, proto_err_q;

    logic [3:0]                     req, sel_d;
    logic                           line_d, wr_d, rd_vld, busy;
    logic [ADDR_SIZE-1:0]           base_d;

    assign req    = {mem_w_line, mem_r_line, mem_w_one, mem_r_one};
    assign sel_d  = req[3] ? 4'b1000 : req[2] ? 4'b0100 : req[1] ? 4'b0010 : {3'b000, req[0]};
    assign line_d = |sel_d[3:2];
    assign wr_d   = sel_d[3] | sel_d[1];
    assign base_d = line_d ? (mem_addr & ~ADDR_SIZE'(CACHE_SIZE - 1)) : mem_addr;
    // rd_vld marks the cycle in which sram_rdata carries data for an earlier read strobe
    assign rd_vld = pipe_q[RD_LAT-1];
    assign busy   = (state_q == WRITE) || (state_q == READ) || (state_q == READ_WAIT);

    assign line_read  = rbuf_q;
    assign mem_ready  = mem_ready_q;
    assign mem_done   = mem_done_q;
    assign proto_err  = proto_err_q;
    assign sram_addr  = sram_addr_q;
    assign sram_we    = sram_we_q;
    assign sram_re    = sram_re_q;
    assign sram_wdata = sram_wdata_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            last_q       <= '0;
            cnt_q        <= '0;
            rcnt_q       <= '0;
            wbuf_q       <= '0;
            rbuf_q       <= '0;
            pipe_q       <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_q    <= 1'b0;
            sram_re_q    <= 1'b0;
            mem_done_q   <= 1'b0;
            mem_ready_q  <= 1'b1;
            proto_err_q  <= 1'b0;
        end else begin
            pipe_q <= (pipe_q << 1) | RD_LAT'(sram_re_q);
            if (rd_vld) begin
                rbuf_q[rcnt_q] <= sram_rdata;
                rcnt_q         <= rcnt_q + CACHE_BITS'(1);
            end
            if (busy && !(|(req & sel_q)))
                proto_err_q <= 1'b1;
            case (state_q)
                IDLE: if (|req) begin
                    state_q     <= wr_d ? WRITE : READ;
                    sel_q       <= sel_d;
                    last_q      <= line_d ? CACHE_BITS'(CACHE_SIZE - 1) : '0;
                    cnt_q       <= '0;
                    rcnt_q      <= '0;
                    sram_addr_q <= base_d;
                    sram_we_q   <= wr_d;
                    sram_re_q   <= !wr_d;
                    mem_ready_q <= 1'b0;
                    if (wr_d) begin
                        wbuf_q       <= line_store;
                        sram_wdata_q <= line_store[0];
                    end
                    if ($countones(req) > 1)
                        proto_err_q <= 1'b1;
                end
                WRITE: if (cnt_q == last_q) begin
                    state_q    <= DONE;
                    sram_we_q  <= 1'b0;
                    mem_done_q <= 1'b1;
                end else begin
                    cnt_q        <= cnt_q + CACHE_BITS'(1);
                    sram_addr_q  <= sram_addr_q + ADDR_SIZE'(1);
                    sram_wdata_q <= wbuf_q[cnt_q + CACHE_BITS'(1)];
                end
                READ: if (cnt_q == last_q) begin
                    state_q   <= READ_WAIT;
                    sram_re_q <= 1'b0;
                end else begin
                    cnt_q       <= cnt_q + CACHE_BITS'(1);
                    sram_addr_q <= sram_addr_q + ADDR_SIZE'(1);
                end
                READ_WAIT: if (rd_vld && rcnt_q == last_q) begin
                    state_q    <= DONE;
                    mem_done_q <= 1'b1;
                end
                DONE: begin
                    state_q    <= RELEASE;
                    mem_done_q <= 1'b0;
                end
                RELEASE: if (!(|req)) begin
                    state_q     <= IDLE;
                    mem_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and randomized checks of mem_responder against a
// word-array memory model and request-level timing rules.
module tb_mem_responder;
    localparam int AW = 8, CB = 2, CS = 4, RL = 2;

    logic clk = 1'b0, rst_l = 1'b0;
    always #5 clk = ~clk;

    logic w_line = 0, r_line = 0, w_one = 0, r_one = 0;
    logic [AW-1:0] addr = '0;
    logic [CS-1:0][31:0] store = '0, lread;
    logic ready, done, perr, we, re;
    logic [AW-1:0] saddr;
    logic [31:0] wdata, rdata;

    int checks = 0, failures = 0;
    logic [31:0] sram [256];
    logic [31:0] exp_mem [256];
    logic [CS-1:0][31:0] exp_rb = '0;
    logic exp_perr = 1'b0;
    logic [RL-1:0][31:0] pipe = '0;

    mem_responder #(.ADDR_SIZE(AW), .CACHE_BITS(CB), .CACHE_SIZE(CS), .RD_LAT(RL)) dut (
        .clk(clk), .rst_l(rst_l),
        .mem_w_line(w_line), .mem_r_line(r_line), .mem_w_one(w_one), .mem_r_one(r_one),
        .mem_addr(addr), .line_store(store), .line_read(lread),
        .mem_ready(ready), .mem_done(done), .proto_err(perr),
        .sram_addr(saddr), .sram_we(we), .sram_re(re), .sram_wdata(wdata), .sram_rdata(rdata)
    );

    // SRAM model: data for a read strobe appears RL cycles later, garbage otherwise
    assign rdata = pipe[RL-1];
    always @(posedge clk) begin
        if (we) sram[saddr] = wdata;
        pipe <= {pipe[RL-2:0], re ? sram[saddr] : $urandom()};
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_image(input string tag);
        int mism = 0;
        for (int i = 0; i < 256; i++) if (sram[i] !== exp_mem[i]) mism++;
        chk(tag, mism, 0);
    endtask

    task automatic run_op(input logic [3:0] rq, input logic [AW-1:0] a,
                          input logic [CS-1:0][31:0] d, input int hold, input int drop_at);
        int pri, n, cyc, nwe, nre, both;
        logic line, wr;
        logic [AW-1:0] b;
        pri  = rq[3] ? 3 : rq[2] ? 2 : rq[1] ? 1 : 0;
        line = pri >= 2;
        wr   = (pri == 3) || (pri == 1);
        n    = line ? CS : 1;
        b    = line ? AW'((int'(a) / CS) * CS) : a;
        if ($countones(rq) > 1 || drop_at > 0) exp_perr = 1'b1;
        @(negedge clk);
        {w_line, r_line, w_one, r_one} = rq;
        addr = a;
        store = d;
        cyc = 0; nwe = 0; nre = 0; both = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("ready_low", ready, 1'b0);
            nwe += int'(we);
            nre += int'(re);
            both += int'(we & re);
            if (cyc == drop_at) {w_line, r_line, w_one, r_one} = 4'b0;
        end while (!done && cyc < 40);
        chk("done_cycle", cyc, wr ? n + 1 : n + RL + 1);
        chk("we_count", nwe, wr ? n : 0);
        chk("re_count", nre, wr ? 0 : n);
        chk("we_re_excl", both, 0);
        for (int i = 0; i < n; i++) begin
            if (wr) exp_mem[AW'(int'(b) + i)] = d[i];
            else exp_rb[i] = exp_mem[AW'(int'(b) + i)];
        end
        chk("line_read_done", lread, exp_rb);
        repeat (hold) begin
            @(negedge clk);
            chk("held_quiet", {ready, done, we, re}, 4'b0);
        end
        {w_line, r_line, w_one, r_one} = 4'b0;
        if (hold == 0) begin
            @(negedge clk);
            chk("release_ready_low", {ready, done}, 2'b00);
        end
        @(negedge clk);
        chk("ready_back", {ready, done}, 2'b10);
        chk("proto_err", perr, exp_perr);
        chk("line_read_hold", lread, exp_rb);
        chk_image("sram_image");
    endtask

    initial begin
        logic [CS-1:0][31:0] d;
        logic [3:0] rq;
        for (int i = 0; i < 256; i++) begin
            sram[i] = $urandom();
            exp_mem[i] = sram[i];
        end
        @(negedge clk);
        chk("reset_outputs", {ready, done, perr, we, re, saddr, wdata}, {5'b10000, 8'h00, 32'h0});
        chk("reset_line_read", lread, '0);
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        chk("idle_ready", {ready, done}, 2'b10);

        d = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
        run_op(4'b1000, 8'h13, d, 0, 0);
        chk("line_write_words", {sram[8'h13], sram[8'h12], sram[8'h11], sram[8'h10]}, d);
        run_op(4'b0100, 8'h10, {4{32'h0}}, 0, 0);
        chk("line_read_data", lread, d);
        run_op(4'b0010, 8'hFF, {96'h0, 32'hCAFE_F00D}, 0, 0);
        run_op(4'b0001, 8'hFF, {4{32'h1234_5678}}, 0, 0);
        chk("word_read_data", lread, {d[3:1], 32'hCAFE_F00D});

        run_op(4'b1001, 8'h24, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 0);
        chk("multi_req_err", perr, 1'b1);
        run_op(4'b0100, 8'h20, '0, 5, 0);
        chk("proto_sticky", perr, 1'b1);

        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        w_line = 1'b1; addr = 8'h40; store = d;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 rst_l = 1'b0;
        #1 chk("async_reset", {we, ready, done, perr, re}, 5'b01000);
        chk("async_reset_rbuf", lread, '0);
        for (int i = 0; i < 3; i++) exp_mem[8'h40 + i] = d[i];
        exp_rb = '0;
        exp_perr = 1'b0;
        w_line = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_done_after_reset", {done, ready, we}, 3'b010);
        end
        chk_image("reset_image");
        run_op(4'b1000, 8'h44, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 0);
        run_op(4'b0100, 8'h40, '0, 0, 0);

        run_op(4'b0100, 8'h80, '0, 0, 2);
        chk("drop_err", perr, 1'b1);
        @(negedge clk);
        rst_l = 1'b0;
        exp_rb = '0;
        exp_perr = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;

        for (int t = 0; t < 30; t++) begin
            rq = 4'b0001 << $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) rq |= 4'($urandom());
            run_op(rq, 8'($urandom()), {$urandom(), $urandom(), $urandom(), $urandom()},
                   $urandom_range(0, 2), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the cache's line/word request interface. Accepts one of four level-held requests (line write, line read, word write, word read) and serializes it into one-word-per-cycle accesses on a single-port, word-wide SRAM with fixed read latency. Signals completion with a one-cycle `mem_done` pulse. Sits between the cache and the backing store, one instance per cache.

## Interface
- `ADDR_SIZE`, default `` `ADDR_SIZE ``: word address width.
- `CACHE_BITS`, default `` `CACHE_BITS ``: log2 of words per line.
- `CACHE_SIZE`, default `` `CACHE_SIZE `` (= 2**CACHE_BITS): words per line.
- `RD_LAT`, default 1, legal 1..4: SRAM read latency in cycles.

- clk  in  1  clock; all logic on rising edge.
- rst_l  in  1  reset, asynchronous, active-low.
- mem_w_line, mem_r_line, mem_w_one, mem_r_one  in  1 each  request levels; held by requester until `mem_done` is seen.
- mem_addr  in  ADDR_SIZE  request word address.
- line_store  in  CACHE_SIZE×32  write data; word ops use `line_store[0]`.
- line_read  out  CACHE_SIZE×32  read data; word ops return in `line_read[0]`.
- mem_ready  out  1  high only in IDLE.
- mem_done  out  1  one-cycle completion pulse.
- proto_err  out  1  sticky protocol-violation flag.
- sram_addr  out  ADDR_SIZE  SRAM word address.
- sram_we  out  1  SRAM write strobe.
- sram_re  out  1  SRAM read strobe.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data; valid RD_LAT cycles after the `sram_re` cycle.

## Operation
- States: IDLE, WRITE, READ, READ_WAIT, DONE, RELEASE.
- IDLE: if any request bit is high at a clock edge, the block accepts it.
  - Priority on acceptance: w_line > r_line > w_one > r_one.
  - Latch op and N (CACHE_SIZE for line ops, 1 for word ops).
  - Latch base address: line ops force `mem_addr[CACHE_BITS-1:0]` to 0; word ops use the full address.
  - Write ops latch `line_store` into the write buffer.
  - Next state is WRITE or READ.
- WRITE:
  - `sram_we`=1, `sram_addr`=base+cnt, `sram_wdata`=wbuf[cnt].
  - cnt runs 0..N-1, one per cycle; after cnt=N-1, go to DONE.
- READ:
  - `sram_re`=1, `sram_addr`=base+cnt, one issue per cycle, cnt 0..N-1; then go to READ_WAIT.
  - A return counter rcnt captures `sram_rdata` into rbuf[rcnt] at the end of each data-valid cycle.
- READ_WAIT: hold until the last return is captured, then go to DONE.
- DONE: `mem_done`=1 for exactly this cycle, then go to RELEASE.
- RELEASE: hold until all four request bits are low for one sampled edge, then go to IDLE. New requests are never accepted in RELEASE.
- `line_read` is driven from rbuf, registered.
  - Stable from DONE until the next read op writes rbuf.
  - Word reads update only rbuf[0]; other entries retain their values.
- Address arithmetic is modulo 2**ADDR_SIZE. Aligned line bursts never wrap, and a word op at the all-ones address is legal.
- `proto_err` sets when either of these occurs; there is no recovery action:
  - more than one request bit is high at the accepting edge;
  - the accepted request bit drops before DONE.
- Accepted ops always run to completion. Only reset clears `proto_err`.
- Reset (any time, including mid-burst):
  - State returns to IDLE immediately.
  - `sram_we`, `sram_re`, `mem_done` and `proto_err` go to 0; `mem_ready`=1.
  - rbuf, wbuf, cnt, rcnt and `line_read` go to 0; `sram_addr` and `sram_wdata` go to 0.

## Timing
- Request first sampled high at edge k: cycles k+1.. are the op cycles.
- Write: `sram_we` high cycles k+1..k+N; `mem_done` in cycle k+N+1.
  - Line write with CACHE_SIZE=4: done at k+5. Word write: done at k+2.
- Read: `sram_re` high cycles k+1..k+N; last data valid in cycle k+N+RD_LAT; `mem_done` in cycle k+N+RD_LAT+1.
  - Line read with N=4, RD_LAT=1: done at k+6.
- `mem_ready` falls in cycle k+1 and rises the cycle after the all-low edge in RELEASE.
- Minimum gap: a request that drops in the DONE+1 cycle allows re-acceptance one edge after returning to IDLE. This is compatible with the requester's flush-to-load idle cycle.
- `sram_we` and `sram_re` are never high in the same cycle.

## Test plan
- Line write at `mem_addr`=0x13 (CACHE_SIZE=4), `line_store`={D3,D2,D1,D0} -> SRAM writes 0x10..0x13 = D0..D3 in cycles k+1..k+4; `mem_done` pulses at k+5.
- Line read of 0x10 with RD_LAT=2 -> `sram_re` high k+1..k+4; `line_read`={D3,D2,D1,D0}; `mem_done` pulse at k+7 only.
- Word write 0xCAFEF00D to the all-ones address, then word read of the same address -> `line_read[0]`=0xCAFEF00D; entries 1..3 unchanged from the prior line read.
- `mem_w_line` and `mem_r_one` high together -> line write is performed; `proto_err`=1 and stays 1 after later clean ops.
- Request held high through DONE for 5 cycles -> no second op starts; `mem_ready`=0 until one edge after the request drops.
- `rst_l` low in the cycle after the third `sram_we` of a line write -> `sram_we`=0 asynchronously; `mem_ready`=1; no `mem_done`; next request is serviced normally.
